// File: rtl/apb_to_axil_bridge.sv
// APB4 completer to AXI4-Lite manager bridge: one APB transfer in flight, each
// transfer becomes exactly one AXI4-Lite write or read, and the response is returned with pready.
module apb_to_axil_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  // APB4 completer
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  input  logic [2:0]            pprot,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] prdata,
  // AXI4-Lite manager, write
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [2:0]            awprot,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_WIDTH-1:0] wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  // AXI4-Lite manager, read
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [2:0]            arprot,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  // debug visibility of the control FSM
  output logic [2:0]            dbg_state_o
);

  // Handshakes: every AXI channel transfers on the rising edge where valid && ready;
  // a raised valid is held, with its payload stable, until that edge.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pslverr_q, pslverr_d;
  logic                  aw_done, w_done;

  // Only the top response bit distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  logic unused_resp_lsb;
  assign unused_resp_lsb = bresp[0] ^ rresp[0];

  // A channel counts as done if it already handshook or handshakes this cycle.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      prot_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      prot_q    <= prot_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      prdata_q  <= prdata_d;
      pslverr_q <= pslverr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    prot_d    = prot_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    prdata_d  = prdata_q;
    pslverr_d = pslverr_q;
    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          wdata_d = pwdata;
          prot_d  = pprot;
          strb_d  = pwrite ? pstrb : '0;
          if (pwrite) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && awready) awvalid_d = 1'b0;
        if (wvalid_q && wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done)    state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          pslverr_d = bresp[1];
          prdata_d  = '0;
          state_d   = DONE;
        end
      end
      RD_REQ: begin
        if (arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (rvalid) begin
          prdata_d  = rdata;
          pslverr_d = rresp[1];
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign bready      = (state_q == WR_RESP);
  assign arvalid     = (state_q == RD_REQ);
  assign rready      = (state_q == RD_RESP);
  assign pready      = (state_q == DONE);
  assign awaddr      = addr_q;
  assign araddr      = addr_q;
  assign awprot      = prot_q;
  assign arprot      = prot_q;
  assign wdata       = wdata_q;
  assign wstrb       = strb_q;
  assign prdata      = prdata_q;
  assign pslverr     = pslverr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_to_axil_bridge.sv
// Bench for apb_to_axil_bridge: directed latency/stall/error/reset cases plus
// randomized transfers against a byte-lane memory model and a configurable AXI subordinate.
module tb_apb_to_axil_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic [SW-1:0] pstrb = '0;
  logic [2:0]    pprot = '0;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp = '0, rresp = '0;
  logic [DW-1:0] rdata = '0;
  logic [2:0]    dbg_state_unused;

  apb_to_axil_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .pready(pready), .pslverr(pslverr), .prdata(prdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .dbg_state_o(dbg_state_unused)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mmem [logic [AW-1:0]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- AXI subordinate (knobs set by the stimulus) ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] cur_bresp = '0, cur_rresp = '0;
  bit spur_mode = 0;
  logic [DW-1:0] smem [logic [AW-1:0]];
  logic [AW-1:0] obs_awaddr = '0, obs_araddr = '0;
  logic [2:0]    obs_awprot = '0, obs_arprot = '0;
  logic [DW-1:0] obs_wdata = '0;
  logic [SW-1:0] obs_wstrb = '0;

  initial begin
    bit got_aw = 0, got_w = 0, got_ar = 0, b_fire = 0, r_fire = 0, spur_active = 0;
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    logic [DW-1:0] wtmp;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        got_aw = 0; got_w = 0; got_ar = 0; b_fire = 0; r_fire = 0;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        continue;
      end
      if (spur_mode) begin
        bvalid = 1; rvalid = 1; bresp = 2'b10; rresp = 2'b11; rdata = 32'hBADBAD00;
        spur_active = 1;
        continue;
      end
      if (spur_active) begin
        bvalid = 0; rvalid = 0; spur_active = 0;
      end
      if (b_fire) begin bvalid = 0; b_fire = 0; got_aw = 0; got_w = 0; b_c = 0; end
      if (r_fire) begin rvalid = 0; r_fire = 0; got_ar = 0; r_c = 0; end
      // responses start only after both request handshakes have completed
      if (got_aw && got_w && !bvalid) begin
        if (b_c >= b_dly) begin
          wtmp = smem.exists(obs_awaddr) ? smem[obs_awaddr] : '0;
          for (int i = 0; i < SW; i++) if (obs_wstrb[i]) wtmp[8*i +: 8] = obs_wdata[8*i +: 8];
          smem[obs_awaddr] = wtmp;
          bvalid = 1; bresp = cur_bresp;
        end else b_c++;
      end
      if (bvalid && bready) b_fire = 1;
      if (got_ar && !rvalid) begin
        if (r_c >= r_dly) begin
          rdata = smem.exists(obs_araddr) ? smem[obs_araddr] : '0;
          rvalid = 1; rresp = cur_rresp;
        end else r_c++;
      end
      if (rvalid && rready) r_fire = 1;
      awready = 0; wready = 0; arready = 0;
      if (awvalid && !got_aw) begin
        if (aw_c >= aw_dly) begin
          awready = 1; got_aw = 1; aw_c = 0; obs_awaddr = awaddr; obs_awprot = awprot;
        end else aw_c++;
      end
      if (wvalid && !got_w) begin
        if (w_c >= w_dly) begin
          wready = 1; got_w = 1; w_c = 0; obs_wdata = wdata; obs_wstrb = wstrb;
        end else w_c++;
      end
      if (arvalid && !got_ar) begin
        if (ar_c >= ar_dly) begin
          arready = 1; got_ar = 1; ar_c = 0; obs_araddr = araddr; obs_arprot = arprot;
        end else ar_c++;
      end
    end
  end

  // ---------------- channel monitor: valid-high cycles and payload stability ----------------
  int aw_hi = 0, w_hi = 0, ar_hi = 0, unstable = 0;
  initial begin
    logic p_aw = 0, p_w = 0, p_ar = 0;
    logic [AW-1:0] p_awaddr = '0, p_araddr = '0;
    logic [DW-1:0] p_wdata = '0;
    logic [SW-1:0] p_wstrb = '0;
    logic [2:0]    p_awprot = '0, p_arprot = '0;
    forever begin
      @(negedge clk);
      if (awvalid) begin
        aw_hi++;
        if (p_aw && (awaddr !== p_awaddr || awprot !== p_awprot)) unstable++;
      end
      if (wvalid) begin
        w_hi++;
        if (p_w && (wdata !== p_wdata || wstrb !== p_wstrb)) unstable++;
      end
      if (arvalid) begin
        ar_hi++;
        if (p_ar && (araddr !== p_araddr || arprot !== p_arprot)) unstable++;
      end
      p_aw = awvalid; p_w = wvalid; p_ar = arvalid;
      p_awaddr = awaddr; p_awprot = awprot; p_wdata = wdata; p_wstrb = wstrb;
      p_araddr = araddr; p_arprot = arprot;
    end
  end

  // ---------------- APB driver ----------------
  int last_bfirst = -1;

  task automatic apb_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [2:0] p,
                          output logic [DW-1:0] rd, output logic err, output int lat);
    int t0, n;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s; pprot = p;
    t0 = cyc; last_bfirst = -1;
    @(negedge clk);
    penable = 1;
    n = 0;
    while (!pready && n < 300) begin
      if (bready && last_bfirst < 0) last_bfirst = cyc - t0;
      @(negedge clk);
      n++;
    end
    if (!pready) check("pready_timeout", 64'(pready), 64'd1);
    lat = cyc - t0;
    rd = prdata; err = pslverr;
    @(negedge clk);
    psel = 0; penable = 0;
    check("pready_single_cycle", 64'(pready), 64'd0);
  endtask

  // ---------------- reference model + transaction wrappers ----------------
  logic [DW-1:0] last_exp_prdata = '0;
  logic          last_exp_err = 1'b0;

  function automatic logic resp_is_err(input logic [1:0] r);
    return (r == 2'b10) || (r == 2'b11);
  endfunction

  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic [2:0] p, input int ad, input int wd, input int bd,
                           input logic [1:0] br);
    logic [DW-1:0] rd, m;
    logic err;
    int lat, aw0, w0, u0;
    aw_dly = ad; w_dly = wd; b_dly = bd; cur_bresp = br;
    aw0 = aw_hi; w0 = w_hi; u0 = unstable;
    m = mmem.exists(a) ? mmem[a] : '0;
    for (int i = 0; i < SW; i++) if (s[i]) m[8*i +: 8] = d[8*i +: 8];
    mmem[a] = m;
    exp_q.push_back('0);
    apb_xfer(1'b1, a, d, s, p, rd, err, lat);
    last_exp_prdata = exp_q.pop_front();
    last_exp_err = resp_is_err(br);
    check("wr_prdata", 64'(rd), 64'(last_exp_prdata));
    check("wr_pslverr", 64'(err), 64'(last_exp_err));
    check("wr_latency", 64'(lat), 64'(3 + ((ad > wd) ? ad : wd) + bd));
    check("wr_awaddr", 64'(obs_awaddr), 64'(a));
    check("wr_awprot", 64'(obs_awprot), 64'(p));
    check("wr_wdata", 64'(obs_wdata), 64'(d));
    check("wr_wstrb", 64'(obs_wstrb), 64'(s));
    check("wr_aw_cycles", 64'(aw_hi - aw0), 64'(ad + 1));
    check("wr_w_cycles", 64'(w_hi - w0), 64'(wd + 1));
    check("wr_stable", 64'(unstable - u0), 64'd0);
  endtask

  task automatic run_read(input logic [AW-1:0] a, input logic [2:0] p, input logic [SW-1:0] s,
                          input int ad, input int rdl, input logic [1:0] rr);
    logic [DW-1:0] rd;
    logic err;
    int lat, ar0, u0;
    ar_dly = ad; r_dly = rdl; cur_rresp = rr;
    ar0 = ar_hi; u0 = unstable;
    exp_q.push_back(mmem.exists(a) ? mmem[a] : '0);
    apb_xfer(1'b0, a, $urandom, s, p, rd, err, lat);
    last_exp_prdata = exp_q.pop_front();
    last_exp_err = resp_is_err(rr);
    check("rd_prdata", 64'(rd), 64'(last_exp_prdata));
    check("rd_pslverr", 64'(err), 64'(last_exp_err));
    check("rd_latency", 64'(lat), 64'(3 + ad + rdl));
    check("rd_araddr", 64'(obs_araddr), 64'(a));
    check("rd_arprot", 64'(obs_arprot), 64'(p));
    check("rd_wstrb_zero", 64'(wstrb), 64'd0);
    check("rd_ar_cycles", 64'(ar_hi - ar0), 64'(ad + 1));
    check("rd_stable", 64'(unstable - u0), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({awvalid, wvalid, bready, arvalid, rready, pready, pslverr}), 64'd0);
    check("rst_prdata", 64'(prdata), 64'd0);
    check("rst_addr", {awaddr, araddr}, 64'd0);
    check("rst_wdata_strb_prot", 64'({wdata, wstrb, awprot, arprot}), 64'd0);
    resetn = 1;
    @(negedge clk);

    // zero-wait write
    run_write(32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0, 0, 0, 2'b00);
    // read with arready stalled 3 cycles and rvalid 2 cycles after the address
    run_write(32'h20, 32'h12345678, 4'hF, 3'b010, 0, 0, 0, 2'b00);
    run_read(32'h20, 3'b001, 4'hF, 3, 2, 2'b00);
    // split write handshake: awready at T1, wready at T4
    run_write(32'h24, 32'hA5A5_5A5A, 4'hF, 3'b100, 0, 3, 0, 2'b00);
    check("split_bready_first", 64'(last_bfirst), 64'd5);
    // error responses, then OKAY clears pslverr
    run_write(32'h28, 32'hCAFEF00D, 4'h3, 3'd0, 0, 0, 1, 2'b10);
    run_read(32'h28, 3'd0, 4'h0, 0, 0, 2'b11);
    run_read(32'h28, 3'd0, 4'h0, 1, 0, 2'b00);
    run_write(32'h2C, 32'h0BAD_F00D, 4'hF, 3'd0, 0, 0, 0, 2'b11);

    // responses arriving while idle are refused and do not disturb held outputs
    spur_mode = 1;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check("spur_bready", 64'(bready), 64'd0);
      check("spur_rready", 64'(rready), 64'd0);
      check("spur_pready", 64'(pready), 64'd0);
    end
    check("spur_prdata_hold", 64'(prdata), 64'(last_exp_prdata));
    check("spur_pslverr_hold", 64'(pslverr), 64'(last_exp_err));
    spur_mode = 0;
    repeat (2) @(negedge clk);
    run_read(32'h10, 3'd5, 4'h0, 0, 0, 2'b01);

    // randomized transfers
    for (int k = 0; k < 150; k++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 7)) << 2;
      if ($urandom_range(0, 1) == 1)
        run_write(a, DW'($urandom), SW'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  2'($urandom_range(0, 3)));
      else
        run_read(a, 3'($urandom_range(0, 7)), SW'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)));
    end

    // reset while waiting for the read response
    ar_dly = 0; r_dly = 20; cur_rresp = 2'b00;
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 0; paddr = 32'h8; pprot = 3'd0;
    @(negedge clk);
    penable = 1;
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    check("mid_rst_in_rd_resp", 64'(rready), 64'd1);
    resetn = 0;
    #1;
    check("mid_rst_arvalid", 64'(arvalid), 64'd0);
    check("mid_rst_rready", 64'(rready), 64'd0);
    check("mid_rst_pready", 64'(pready), 64'd0);
    check("mid_rst_addr", {awaddr, araddr}, 64'd0);
    @(negedge clk);
    psel = 0; penable = 0;
    repeat (2) @(negedge clk);
    check("mid_rst_no_pready", 64'(pready), 64'd0);
    resetn = 1;
    @(negedge clk);
    run_write(32'h4, 32'h600D_CAFE, 4'hF, 3'd0, 0, 0, 0, 2'b00);
    run_read(32'h4, 3'd0, 4'h0, 0, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_to_axil_bridge.md
APB_TO_AXIL_BRIDGE -- requirements
Module: apb_to_axil_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width on both ports; STRB = DATA_WIDTH/8.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have APB4 completer inputs psel, penable, pwrite (1 each), paddr (ADDR_WIDTH), pwdata (DATA_WIDTH), pstrb (STRB), pprot (3).
REQ-006 SHALL have APB4 completer outputs pready (1), pslverr (1), prdata (DATA_WIDTH).
REQ-007 SHALL have AXI4-Lite manager write ports: awvalid out 1, awready in 1, awaddr out ADDR_WIDTH, awprot out 3, wvalid out 1, wready in 1, wdata out DATA_WIDTH, wstrb out STRB, bvalid in 1, bready out 1, bresp in 2.
REQ-008 SHALL have AXI4-Lite manager read ports: arvalid out 1, arready in 1, araddr out ADDR_WIDTH, arprot out 3, rvalid in 1, rready out 1, rdata in DATA_WIDTH, rresp in 2.

Function
REQ-009 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE; one APB transfer outstanding at a time.
REQ-010 IDLE: on psel && !penable (setup phase), SHALL latch paddr, pwdata, pprot, pwrite, and pstrb (pstrb only if pwrite, else 0); go to WR_REQ if pwrite, else RD_REQ.
REQ-011 WR_REQ: awvalid and wvalid SHALL both rise on entry; each SHALL drop independently the cycle after its own handshake (valid && ready); neither SHALL deassert before handshake; go to WR_RESP once both handshakes are done (same-cycle handshakes allowed).
REQ-012 WR_RESP: bready SHALL be 1; on bvalid, SHALL capture pslverr = bresp[1], set prdata = 0, go to DONE.
REQ-013 RD_REQ: arvalid SHALL be 1 until arready; then go to RD_RESP.
REQ-014 RD_RESP: rready SHALL be 1; on rvalid, SHALL capture prdata = rdata and pslverr = rresp[1], go to DONE.
REQ-015 DONE: pready SHALL be 1 for exactly one cycle, then return to IDLE; pready SHALL be 0 in all other states.
REQ-016 awaddr/araddr/awprot/arprot/wdata/wstrb SHALL be driven from the latched registers and held stable while the corresponding valid is high.
REQ-017 bresp/rresp values 2'b10 (SLVERR) and 2'b11 (DECERR) SHALL map to pslverr=1; 2'b00/2'b01 SHALL map to pslverr=0.
REQ-018 prdata and pslverr SHALL hold their captured values until the next capture; both are meaningful only when pready=1.
REQ-019 With zero-wait AXI (all ready high, response in the next cycle), setup at cycle T0 SHALL give valid(s) at T1, response handshake at T2, pready=1 at T3.
REQ-020 A new setup phase seen in any state other than IDLE SHALL be ignored; the in-flight AXI transaction SHALL always run to completion.
REQ-021 If psel drops before DONE (APB protocol violation), the bridge SHALL finish the AXI transaction, pass through DONE, and return to IDLE.
REQ-022 bvalid/rvalid arriving outside WR_RESP/RD_RESP SHALL be ignored (bready/rready low).

Reset
REQ-023 On resetn low, SHALL enter IDLE asynchronously and drive awvalid, wvalid, bready, arvalid, rready, pready, pslverr = 0; prdata, awaddr, araddr, wdata = 0; wstrb, awprot, arprot = 0.
REQ-024 Reset mid-transaction SHALL abandon the transfer with no pready pulse; first transfer after reset release SHALL behave as from IDLE.

Verification
REQ-025 Write, zero-wait: paddr=0x10, pwdata=0xDEADBEEF, pstrb=0xF -> awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF at T1; bresp=00 at T2; pready=1, pslverr=0 at T3.
REQ-026 Read with AXI stalls: paddr=0x20, arready low 3 cycles, rvalid 2 cycles later with rdata=0x12345678, rresp=00 -> arvalid held 4 cycles, araddr stable; pready=1 with prdata=0x12345678 one cycle after the rvalid handshake.
REQ-027 Split write handshake: awready at T1, wready only at T4 -> awvalid low from T2, wvalid high T1-T4, bready asserted from T5, no pready before bvalid.
REQ-028 Error responses: write with bresp=10 -> pslverr=1; read with rresp=11 -> pslverr=1, prdata=rdata; following OKAY read -> pslverr=0.
REQ-029 Reset mid-read: resetn low while in RD_RESP -> arvalid, rready, pready = 0 immediately; after release, a write to 0x4 completes per REQ-025 timing.
